serial_adder: RTL
=================

# serial_adder

Bit-serial unsigned adder that computes `a + b` one bit per clock, LSB first, using a single full-adder cell and a registered carry. It is the additive counterpart of the team's subtractor cells: feeding its `sum` and `b` back through a subtractor recovers `a`. It sits between a valid/ready producer and a valid/ready consumer, trading latency for area.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range ≥ 1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: producer presents operands `a` and `b`.
- `in_ready` out 1: block can accept operands; high only in IDLE.
- `a` in WIDTH: first operand, unsigned.
- `b` in WIDTH: second operand, unsigned.
- `out_valid` out 1: `sum` and `carry_out` are valid; high only in DONE.
- `out_ready` in 1: consumer accepts the result.
- `sum` out WIDTH: `(a + b) mod 2^WIDTH`.
- `carry_out` out 1: bit WIDTH of `a + b`.
- `busy` out 1: high in RUN and DONE.

## Operation
- FSM with three states: IDLE, RUN, DONE. Reset state is IDLE.
- **IDLE.** `in_ready` = 1.
  - On an edge where `in_valid && in_ready`: load shift registers `sa` ← `a` and `sb` ← `b`, clear the carry register `c` ← 0, clear counter `cnt` ← 0, clear the sum shift register, and go to RUN.
- **RUN.** Each edge:
  - `s = sa[0] ^ sb[0] ^ c`.
  - `c ← (sa[0]&sb[0]) | (sa[0]&c) | (sb[0]&c)`.
  - `sa` and `sb` shift right by 1.
  - The sum register shifts right with `s` inserted at bit WIDTH-1.
  - `cnt ← cnt+1`.
  - On the edge where `cnt == WIDTH-1`, the last bit is processed and the FSM goes to DONE.
- **DONE.** `out_valid` = 1.
  - `sum` and `carry_out` = `c` are held stable while `out_ready` = 0.
  - On an edge with `out_ready` = 1, go to IDLE.
- Operand and result shift registers are WIDTH bits wide. `cnt` is `$clog2(WIDTH+1)` bits wide. There is no sign handling.
- `in_valid` is ignored outside IDLE; operands change only on accept.
- `out_ready` is ignored outside DONE.
- `sum` and `carry_out` may take any value outside DONE; the bench checks them only when `out_valid` = 1.
- WIDTH = 1: RUN lasts exactly one edge.

## Timing
- Values after any reset edge: `in_ready` = 1, `out_valid` = 0, `busy` = 0, `sum` = 0, `carry_out` = 0, `cnt` = 0, `c` = 0.
- Handshake rules:
  - A transfer occurs on a rising edge where valid and ready are both high.
  - `in_ready` and `out_valid` are functions of the state register only. There is no combinational path from `in_valid` or `out_ready`.
- Latency: accept at edge E0, then RUN on edges E1..EWIDTH, then `out_valid` is high in the cycle after edge E0+WIDTH.
- Result consumed at edge Ed: `in_ready` = 1 in the cycle after Ed.
- Minimum initiation interval: WIDTH+2 cycles (accept edge, WIDTH RUN edges, consume edge). No overlap of operations.
- Reset mid-operation: `rst` high at any edge in RUN or DONE aborts the operation.
  - The FSM returns to IDLE with all reset values above.
  - The pending result is discarded and never presented.
- `rst` has priority over every handshake on the same edge.

## Test plan
- **Basic add.** WIDTH=8, `a`=5, `b`=3, `out_ready` tied 1.
  - `sum`=8, `carry_out`=0.
  - `out_valid` rises exactly 8 edges after the accept edge and lasts 1 cycle.
- **Overflow.** `a`=255, `b`=1 gives `sum`=0, `carry_out`=1. `a`=255, `b`=255 gives `sum`=254, `carry_out`=1. `a`=0, `b`=0 gives `sum`=0, `carry_out`=0.
- **Backpressure.** `a`=100, `b`=27, `out_ready` held 0 for 5 cycles after `out_valid` rises.
  - `sum`=127 and `out_valid`=1 stay stable for all 5 cycles.
  - `in_ready` stays 0 until one cycle after `out_ready` = 1 is sampled.
- **Ignored input.** `in_valid` held high with changing `a`/`b` during RUN and DONE.
  - The result reflects only the operands sampled at the accept edge.
  - Exactly one result is produced per accept.
- **Reset mid-operation.** Accept `a`=200, `b`=100, then assert `rst` for 1 edge after 3 RUN edges.
  - Next cycle: `in_ready`=1, `out_valid`=0, `busy`=0.
  - A following `a`=7, `b`=9 yields `sum`=16, `carry_out`=0.
- **Back-to-back and sweep.** `in_valid` and `out_ready` tied 1.
  - 50 random pairs at WIDTH=8 and all 4 pairs at WIDTH=1 match `a+b` per a reference model.
  - Spacing between successive accepts is exactly WIDTH+2 cycles.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder -- bit-serial unsigned adder, one bit per clock, LSB first.
//
// A single full-adder cell works through the operands while a registered
// carry links consecutive bits. Operands are taken on a valid/ready
// handshake in IDLE. The result is presented on a second valid/ready
// handshake in DONE and is held until the consumer accepts it.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   producer presents a/b
//   in_ready   block can accept operands (IDLE only)
//   a, b       unsigned operands, WIDTH bits
//   out_valid  sum/carry_out are valid (DONE only)
//   out_ready  consumer accepts the result
//   sum        (a + b) mod 2^WIDTH
//   carry_out  bit WIDTH of a + b
//   busy       operation in progress (RUN or DONE)
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] ss;
  logic             c;
  logic [CNT_W-1:0] cnt;

  logic             s_bit;
  logic             c_next;
  logic [WIDTH-1:0] ss_next;
  logic             last;

  // Full-adder cell on the current LSBs. The new sum bit enters at the top
  // of the result register, so after WIDTH shifts bit 0 sits at the bottom.
  // Built by shift-then-overwrite so WIDTH = 1 needs no zero-width slice.
  always_comb begin
    s_bit              = sa[0] ^ sb[0] ^ c;
    c_next             = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
    ss_next            = ss >> 1;
    ss_next[WIDTH-1]   = s_bit;
    last               = (cnt == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sa        <= '0;
      sb        <= '0;
      ss        <= '0;
      c         <= 1'b0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            sa       <= a;
            sb       <= b;
            ss       <= '0;
            c        <= 1'b0;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          ss  <= ss_next;
          c   <= c_next;
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign sum       = ss;
  assign carry_out = c;

endmodule
